cbm2_segreg: RTL
================

CBM2_SEGREG -- requirements
Module: cbm2_segreg

Interface
REQ-001 clk_sys  input  1  system clock; all state changes on rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset.
REQ-003 cpu_en  input  1  one-clk_sys strobe marking completion of one 6509 bus cycle.
REQ-004 sync  input  1  current bus cycle is an opcode fetch.
REQ-005 intr  input  1  core is entering an interrupt sequence, so the fetched opcode is discarded.
REQ-006 cpuAddr  input  16  CPU address of current cycle.
REQ-007 cpuDo  input  8  CPU write data.
REQ-008 cpuWe  input  1  CPU write strobe for current cycle.
REQ-009 busDi  input  8  read data returned by the bus logic for current cycle.
REQ-010 cpuSeg  output  8  segment for current cycle, {4'h0, bank}; feeds bus logic cpuSeg.
REQ-011 regSel  output  1  current cycle addresses $0000 or $0001 in any segment.
REQ-012 regDo  output  8  register read data, {4'h0, bank register}; valid when regSel=1.
REQ-013 indActive  output  1  current cycle uses the indirection bank.

Function
REQ-014 Two 4-bit registers SHALL be held: EXB (execution bank, address $0000) and INB (indirection bank, address $0001).
REQ-015 On cpu_en with cpuWe=1 and cpuAddr=$0000, EXB SHALL load cpuDo[3:0], whatever the current segment; for cpuAddr=$0001, INB SHALL load cpuDo[3:0].
REQ-016 The write SHALL still pass to the bus unchanged; the RAM copy is written as normal.
REQ-017 regSel SHALL equal (cpuAddr[15:1]==0), combinational; regDo SHALL be {4'h0, EXB} for $0000 and {4'h0, INB} for $0001.
REQ-018 A read of $0000/$0001 SHALL return the register value, not RAM; bits 7:4 SHALL read 0.
REQ-019 cpuSeg SHALL be combinational: {4'h0, INB} when indActive=1, else {4'h0, EXB}.
REQ-020 A register write SHALL take effect from the cycle after its cpu_en; the write cycle itself uses the old value.
REQ-021 The FSM SHALL advance only on cpu_en and SHALL hold state while cpu_en=0 (RDY stall).
REQ-022 FSM states: IDLE, ZP, PTRL, PTRH, IND.
REQ-023 Any state, cpu_en with sync=1: go to ZP if busDi is $B1 (LDA (zp),Y) or $91 (STA (zp),Y) and intr=0; otherwise go to IDLE.
REQ-024 ZP -> PTRL -> PTRH -> IND, each transition on cpu_en with sync=0.
REQ-025 IND SHALL persist on cpu_en with sync=0; this covers the page-cross dummy read, the LDA data read, and the STA dummy read plus write.
REQ-026 indActive SHALL be 1 exactly while state=IND and sync=0; a sync cycle always uses EXB.
REQ-027 In IND, a write to $0001 SHALL update INB; the new value is used from the next cycle.
REQ-028 sync=1 in ZP, PTRL or PTRH (abnormal sequence) SHALL be handled by REQ-023 with no indirect cycle.
REQ-029 If cpu_en=1 and sync=1 occur in the same clock as an IND cycle, sync SHALL take priority; that cycle is not indirect.
REQ-030 No combinational path SHALL exist from busDi to cpuSeg; opcode decode SHALL affect only the registered state.

Reset
REQ-031 While reset_n=0 at a clock edge: EXB=$F, INB=$F, state=IDLE.
REQ-032 Outputs after reset: cpuSeg=$0F, indActive=0; regSel and regDo follow cpuAddr combinationally.
REQ-033 Reset asserted mid-sequence (any state) SHALL abort to IDLE in one clock, with no indirect cycle after release.

Verification
REQ-034 Reset then sync fetch at $E000 -> cpuSeg=$0F, indActive=0, regDo at $0000=$0F.
REQ-035 Write $21 to $0001, then read $0001 -> regSel=1, regDo=$01, EXB unchanged ($F).
REQ-036 INB=1, opcode $B1 with no page cross -> cycles 2-4 cpuSeg=$0F, cycle 5 cpuSeg=$01 with indActive=1, next sync cpuSeg=$0F.
REQ-037 INB=2, opcode $91 -> cycles 5 (dummy read) and 6 (write) cpuSeg=$02; cpu_en held low 3 clocks in cycle 4 -> state and cpuSeg stable throughout.
REQ-038 Opcode $B1 fetched with intr=1 -> no indirect cycle; write $03 to $0000 -> cpuSeg=$03 from the next cycle.
REQ-039 Reset_n pulsed low during IND -> state IDLE, EXB=INB=$F, indActive=0 on the following cycle.

Source files
------------

// File: rtl/cbm2_segreg.sv
// cbm2_segreg: CBM-II 6509 execution/indirection bank registers and indirect-cycle tracker
module cbm2_segreg (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cpu_en,
    input  logic        sync,
    input  logic        intr,
    input  logic [15:0] cpuAddr,
    input  logic [7:0]  cpuDo,
    input  logic        cpuWe,
    input  logic [7:0]  busDi,
    output logic [7:0]  cpuSeg,
    output logic        regSel,
    output logic [7:0]  regDo,
    output logic        indActive
);
    typedef enum logic [2:0] {IDLE, ZP, PTRL, PTRH, IND} state_t;
    state_t     state, stateNext;
    logic [3:0] exb, inb;
    logic       isIndOp;
    logic       unusedHighData;
    assign unusedHighData = ^cpuDo[7:4];
    assign regSel    = cpuAddr[15:1] == 15'h0;
    assign regDo     = {4'h0, cpuAddr[0] ? inb : exb};
    assign indActive = (state == IND) && !sync;
    assign cpuSeg    = {4'h0, indActive ? inb : exb};
    assign isIndOp   = (busDi == 8'hB1 || busDi == 8'h91) && !intr;
    // bank registers shadow writes to $0000/$0001 in every segment; the bus still sees the write
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            exb <= 4'hF;
            inb <= 4'hF;
        end else if (cpu_en && cpuWe && regSel) begin
            exb <= cpuAddr[0] ? exb : cpuDo[3:0];
            inb <= cpuAddr[0] ? cpuDo[3:0] : inb;
        end
    end
    // sequence state advances only on completed bus cycles
    always_ff @(posedge clk_sys) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end
    // opcode fetch restarts tracking; (zp),Y walks ZP->PTRL->PTRH->IND and stays in IND
    always_comb begin
        stateNext = state;
        if (cpu_en && sync) stateNext = isIndOp ? ZP : IDLE;
        else if (cpu_en) begin
            case (state)
                ZP:      stateNext = PTRL;
                PTRL:    stateNext = PTRH;
                PTRH:    stateNext = IND;
                default: stateNext = state;
            endcase
        end
    end
endmodule
